// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type and decimal correction constants
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_CORR = 4'd6;
endpackage

// File: rtl/bcd_adder_if.sv
// bcd_adder_if: operand/result bundle for the registered BCD adder
interface bcd_adder_if #(parameter int NUM_DIGITS = 1);
  localparam int W = 4 * NUM_DIGITS;
  logic in_valid;
  logic [W-1:0] Augend;
  logic [W-1:0] Addend;
  logic cin;
  logic out_valid;
  logic [W-1:0] sum;
  logic outcarry;
  logic err;
  modport master(output in_valid, Augend, Addend, cin, input out_valid, sum, outcarry, err);
  modport slave(input in_valid, Augend, Addend, cin, output out_valid, sum, outcarry, err);
endinterface

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational single-digit BCD adder with decimal carry and bad-digit flag
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       ci,
  output bcd_digit_t s,
  output logic       co,
  output logic       bad
);
  logic [4:0] z;
  assign z = {1'b0, a} + {1'b0, b} + {4'b0, ci};
  assign co = z > {1'b0, BCD_MAX};
  assign s = co ? z[3:0] + BCD_CORR : z[3:0];
  assign bad = (a > BCD_MAX) || (b > BCD_MAX);
endmodule

// File: rtl/bcd_adder.sv
// bcd_adder: ripple-carry packed-BCD adder with a single registered output stage
module bcd_adder
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 1
) (
  input logic clk,
  input logic rst,
  bcd_adder_if.slave bus
);
  localparam int W = 4 * NUM_DIGITS;
  logic c [NUM_DIGITS+1];
  logic [W-1:0] s;
  logic [NUM_DIGITS-1:0] bad;
  assign c[0] = bus.cin;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit_add u_dig (
      .a  (bus.Augend[4*i+:4]),
      .b  (bus.Addend[4*i+:4]),
      .ci (c[i]),
      .s  (s[4*i+:4]),
      .co (c[i+1]),
      .bad(bad[i])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.sum <= '0;
      bus.outcarry <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.sum <= s;
        bus.outcarry <= c[NUM_DIGITS];
        bus.err <= |bad;
      end
    end
  end
endmodule

// File: tb/tb_bcd_adder.sv
// tb_bcd_adder: randomized and directed checks of 1- and 2-digit BCD adders against a decimal model
module tb_bcd_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_adder_if #(.NUM_DIGITS(1)) i1 ();
  bcd_adder_if #(.NUM_DIGITS(2)) i2 ();

  bcd_adder #(.NUM_DIGITS(1)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));
  bcd_adder #(.NUM_DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(i2.slave));

  int vectors = 0;
  int miscompares = 0;

  // observed result packed as {out_valid, outcarry, err, sum[7:0]}
  function automatic logic [10:0] obs(int nd);
    return (nd == 1) ? {i1.out_valid, i1.outcarry, i1.err, 4'h0, i1.sum}
                     : {i2.out_valid, i2.outcarry, i2.err, i2.sum};
  endfunction

  task automatic drive(int nd, logic v, logic [7:0] a, logic [7:0] b, logic ci);
    if (nd == 1) begin
      i1.in_valid = v; i1.Augend = a[3:0]; i1.Addend = b[3:0]; i1.cin = ci;
    end else begin
      i2.in_valid = v; i2.Augend = a; i2.Addend = b; i2.cin = ci;
    end
  endtask

  // decimal reference for valid operands: plain integer arithmetic
  function automatic logic [10:0] dec_model(int nd, logic [7:0] a, logic [7:0] b, logic ci);
    int da, db, t, lim, r;
    logic [7:0] sb;
    da = int'(a[3:0]) + (nd == 2 ? 10 * int'(a[7:4]) : 0);
    db = int'(b[3:0]) + (nd == 2 ? 10 * int'(b[7:4]) : 0);
    t = da + db + int'(ci);
    lim = (nd == 1) ? 10 : 100;
    r = t % lim;
    sb = 8'(((r / 10) << 4) | (r % 10));
    return {1'b1, t >= lim, 1'b0, sb};
  endfunction

  // digit-rule reference covering invalid digits
  function automatic logic [10:0] rule_model(int nd, logic [7:0] a, logic [7:0] b, logic ci);
    int c, da, db, z;
    logic [7:0] s;
    logic e;
    c = int'(ci); s = '0; e = 1'b0;
    for (int i = 0; i < nd; i++) begin
      da = (int'(a) >> (4 * i)) & 15;
      db = (int'(b) >> (4 * i)) & 15;
      if (da > 9 || db > 9) e = 1'b1;
      z = da + db + c;
      c = (z > 9) ? 1 : 0;
      s = s | 8'((((z > 9) ? z + 6 : z) % 16) << (4 * i));
    end
    return {1'b1, c[0], e, s};
  endfunction

  function automatic logic [7:0] rnd_bcd(int nd);
    logic [7:0] v;
    v = {4'($urandom_range(9)), 4'($urandom_range(9))};
    if (nd == 1) v[7:4] = 4'h0;
    return v;
  endfunction

  task automatic test_reset();
    logic [10:0] got;
    drive(1, 1'b1, 8'h09, 8'h09, 1'b1);
    drive(2, 1'b1, 8'h99, 8'h99, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int nd = 1; nd <= 2; nd++) begin
      got = obs(nd); vectors++;
      if (got !== 11'h0) begin
        miscompares++; $display("FAIL reset_held nd=%0d got=%h exp=%h", nd, got, 11'h0);
      end
    end
    rst = 1'b0;
    drive(1, 1'b0, 8'h0, 8'h0, 1'b0);
    drive(2, 1'b0, 8'h0, 8'h0, 1'b0);
    @(negedge clk);
    for (int nd = 1; nd <= 2; nd++) begin
      got = obs(nd); vectors++;
      if (got !== 11'h0) begin
        miscompares++; $display("FAIL reset_release nd=%0d got=%h exp=%h", nd, got, 11'h0);
      end
    end
  endtask

  task automatic test_single_digit();
    int ta [11] = '{3, 4, 9, 9, 0, 8, 7, 2, 8, 9, 3};
    int tb [11] = '{6, 9, 9, 9, 0, 7, 6, 5, 8, 1, 5};
    int tc [11] = '{1, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0};
    int ts [11] = '{0, 3, 8, 9, 0, 5, 4, 8, 6, 1, 8};
    int to [11] = '{1, 1, 1, 1, 0, 1, 1, 0, 1, 1, 0};
    logic [10:0] got, e;
    for (int k = 0; k < 11; k++) begin
      drive(1, 1'b1, 8'(ta[k]), 8'(tb[k]), tc[k][0]);
      e = {1'b1, to[k][0], 1'b0, 4'h0, 4'(ts[k])};
      @(negedge clk);
      got = obs(1); vectors++;
      if (got !== e) begin
        miscompares++; $display("FAIL single k=%0d got=%h exp=%h", k, got, e);
      end
      drive(1, 1'b0, 8'h0, 8'h0, 1'b0);
      @(negedge clk);
      got = obs(1); vectors++;
      if (got !== {1'b0, e[9:0]}) begin
        miscompares++; $display("FAIL single_hold k=%0d got=%h exp=%h", k, got, {1'b0, e[9:0]});
      end
    end
  endtask

  task automatic test_back_to_back(int nd);
    logic [10:0] got, e;
    logic [7:0] a, b;
    logic ci;
    e = '0;
    for (int k = 0; k < 10; k++) begin
      a = rnd_bcd(nd); b = rnd_bcd(nd); ci = 1'($urandom_range(1));
      e = dec_model(nd, a, b, ci);
      drive(nd, 1'b1, a, b, ci);
      @(negedge clk);
      got = obs(nd); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL b2b nd=%0d k=%0d a=%h b=%h ci=%0d got=%h exp=%h", nd, k, a, b, ci, got, e);
      end
    end
    drive(nd, 1'b0, 8'h55, 8'h44, 1'b1);
    @(negedge clk);
    got = obs(nd); vectors++;
    if (got !== {1'b0, e[9:0]}) begin
      miscompares++; $display("FAIL b2b_hold nd=%0d got=%h exp=%h", nd, got, {1'b0, e[9:0]});
    end
  endtask

  task automatic test_err();
    logic [10:0] got, e;
    logic [7:0] a, b;
    drive(1, 1'b1, 8'h0C, 8'h01, 1'b0);
    @(negedge clk);
    got = obs(1); vectors++;
    if (got !== 11'b1_1_1_0000_0011) begin
      miscompares++; $display("FAIL err_digit got=%h exp=%h", got, 11'b1_1_1_0000_0011);
    end
    drive(1, 1'b1, 8'h01, 8'h01, 1'b0);
    @(negedge clk);
    got = obs(1); vectors++;
    if (got !== 11'b1_0_0_0000_0010) begin
      miscompares++; $display("FAIL err_clear got=%h exp=%h", got, 11'b1_0_0_0000_0010);
    end
    drive(1, 1'b0, 8'h0, 8'h0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      a = 8'($urandom); b = 8'($urandom);
      if (k == 0) a = 8'hA0;
      e = rule_model(2, a, b, k[0]);
      drive(2, 1'b1, a, b, k[0]);
      @(negedge clk);
      got = obs(2); vectors++;
      if (got !== e) begin
        miscompares++; $display("FAIL err_raw k=%0d a=%h b=%h got=%h exp=%h", k, a, b, got, e);
      end
    end
    drive(2, 1'b0, 8'h0, 8'h0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_two_digit();
    logic [10:0] got;
    drive(2, 1'b1, 8'h99, 8'h99, 1'b1);
    @(negedge clk);
    got = obs(2); vectors++;
    if (got !== {3'b110, 8'h99}) begin
      miscompares++; $display("FAIL two_max got=%h exp=%h", got, {3'b110, 8'h99});
    end
    drive(2, 1'b1, 8'h45, 8'h55, 1'b0);
    @(negedge clk);
    got = obs(2); vectors++;
    if (got !== {3'b110, 8'h00}) begin
      miscompares++; $display("FAIL two_45_55 got=%h exp=%h", got, {3'b110, 8'h00});
    end
    drive(2, 1'b1, 8'h37, 8'h28, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    got = obs(2); vectors++;
    if (got !== 11'h0) begin
      miscompares++; $display("FAIL rst_mid got=%h exp=%h", got, 11'h0);
    end
    rst = 1'b0;
    drive(2, 1'b0, 8'h0, 8'h0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_back_to_back(1);
    test_back_to_back(2);
    test_err();
    test_two_digit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
